// File: rtl/multi_value_pixel_renderer_if.sv
// Bundles the value-capture handshake and the pixel request/response bus
// shared between the value producers, the scan controller and the renderer.
interface multi_value_pixel_renderer_if #(
  parameter int NUM_CH   = 2,
  parameter int VALUE_W  = 10,
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6
);
  logic [NUM_CH*VALUE_W-1:0]    values;
  logic                         values_valid;
  logic                         values_ready;
  logic                         frame_start;
  logic [ROW_BITS+COL_BITS-1:0] pixel_addr;
  logic                         pixel_req;
  logic [23:0]                  pixel_data;
  logic                         pixel_valid;
  logic [NUM_CH-1:0]            overflow;

  modport master (
    output values, values_valid, frame_start, pixel_addr, pixel_req,
    input  values_ready, pixel_data, pixel_valid, overflow
  );

  modport slave (
    input  values, values_valid, frame_start, pixel_addr, pixel_req,
    output values_ready, pixel_data, pixel_valid, overflow
  );
endinterface

// File: rtl/multi_value_pixel_renderer.sv
// Numeric overlay pixel source: double-dabble conversion into a shadow bank,
// swapped into the active bank at frame start, rendered via a 2-stage pipeline.
//   state   | meaning
//   IDLE    | ready for a capture
//   LOAD    | saturate value[ch], seed shift register, clear BCD
//   SHIFT   | VALUE_W add-3/shift steps
//   STORE   | write blanked digits and sat flag to shadow[ch]
module multi_value_pixel_renderer #(
  parameter int NUM_CH      = 2,
  parameter int DIGITS      = 3,
  parameter int VALUE_W     = 10,
  parameter int ROW_BITS    = 5,
  parameter int COL_BITS    = 6,
  parameter int ROW0        = 12,
  parameter int COL0        = 4,
  parameter int CH_PITCH    = 32,
  parameter int DIGIT_PITCH = 6,
  parameter logic [NUM_CH*24-1:0] CH_COLORS = {24'h0000FF, 24'hFF0000},
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic clk,
  input  logic rst,
  multi_value_pixel_renderer_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;
  localparam logic [3:0] BLANK = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_e;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VALUE_W-1:0]   val_q [NUM_CH];
  logic [VALUE_W-1:0]   val_d [NUM_CH];
  logic [VALUE_W-1:0]   sh_q, sh_d;
  logic [DIGITS*4-1:0]  bcd_q, bcd_d;
  logic                 sat_q, sat_d;
  logic                 pending_q, pending_d;
  logic [3:0]           shadow_q [NUM_CH][DIGITS];
  logic [3:0]           shadow_d [NUM_CH][DIGITS];
  logic [3:0]           active_q [NUM_CH][DIGITS];
  logic [3:0]           active_d [NUM_CH][DIGITS];
  logic [NUM_CH-1:0]    shadow_sat_q, shadow_sat_d;
  logic [NUM_CH-1:0]    active_sat_q, active_sat_d;

  logic [VALUE_W-1:0]   cur_val;
  logic [DIGITS*4-1:0]  bcd_adj;
  logic [3:0]           dig_blk [DIGITS];
  logic                 lead;
  logic                 last_store;
  logic                 swap;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    val_d        = val_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    sat_d        = sat_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    shadow_sat_d = shadow_sat_q;
    active_sat_d = active_sat_q;
    cur_val      = val_q[ch_q];
    bcd_adj      = bcd_q;
    lead         = 1'b1;

    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Position 0 is the most significant digit; the last position is never blanked.
    for (int d = 0; d < DIGITS; d++) begin
      dig_blk[d] = bcd_q[4*(DIGITS-1-d) +: 4];
      if (lead && dig_blk[d] == 4'd0 && d != DIGITS-1) dig_blk[d] = BLANK;
      else lead = 1'b0;
    end

    last_store = (state_q == S_STORE) && (ch_q == CH_W'(NUM_CH-1));
    swap       = bus.frame_start && pending_q && !last_store;

    case (state_q)
      S_IDLE: begin
        if (bus.values_valid) begin
          for (int c = 0; c < NUM_CH; c++) val_d[c] = bus.values[VALUE_W*c +: VALUE_W];
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (32'(cur_val) > MAX_VAL) begin
          sh_d  = VALUE_W'(MAX_VAL);
          sat_d = 1'b1;
        end else begin
          sh_d  = cur_val;
          sat_d = 1'b0;
        end
        bcd_d   = '0;
        cnt_d   = CNT_W'(VALUE_W - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj[DIGITS*4-2:0], sh_q, 1'b0};
        if (cnt_q == '0) state_d = S_STORE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_STORE: begin
        for (int d = 0; d < DIGITS; d++) shadow_d[ch_q][d] = dig_blk[d];
        shadow_sat_d[ch_q] = sat_q;
        if (last_store) begin
          pending_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (swap) begin
      active_d     = shadow_q;
      active_sat_d = shadow_sat_q;
      pending_d    = 1'b0;
    end
  end

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  assign {row, col} = bus.pixel_addr;

  logic            valid1_q, valid1_d, hit1_q, hit1_d;
  logic [CH_W-1:0] ch1_q, ch1_d;
  logic [3:0]      code1_q, code1_d;
  logic [2:0]      x1_q, x1_d, y1_q, y1_d;
  logic            valid2_q;
  logic [23:0]     pix_q, pix_d;
  logic [4:0]      frow;
  logic            lit;
  int              box_col;

  // Descending scan so the lowest channel's box overrides any overlap.
  always_comb begin
    valid1_d = bus.pixel_req;
    hit1_d   = 1'b0;
    ch1_d    = '0;
    code1_d  = BLANK;
    x1_d     = '0;
    y1_d     = '0;
    box_col  = 0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      for (int d = DIGITS-1; d >= 0; d--) begin
        box_col = COL0 + c*CH_PITCH + d*DIGIT_PITCH;
        if (int'(col) >= box_col && int'(col) <= box_col + 4 &&
            int'(row) >= ROW0 && int'(row) <= ROW0 + 6) begin
          hit1_d  = 1'b1;
          ch1_d   = CH_W'(c);
          code1_d = active_q[c][d];
          x1_d    = 3'(int'(col) - box_col);
          y1_d    = 3'(int'(row) - ROW0);
        end
      end
    end
  end

  function automatic logic [4:0] font_row(input logic [3:0] code, input logic [2:0] y);
    logic [34:0] g;
    case (code)
      4'd0: g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'd1: g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'd2: g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'd3: g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'd4: g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'd5: g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'd6: g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'd7: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'd8: g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'd9: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      default: g = '0;
    endcase
    if (y > 3'd6) font_row = 5'h00;
    else          font_row = g[5*(6-int'(y)) +: 5];
  endfunction

  always_comb begin
    frow  = font_row(code1_q, y1_q);
    lit   = hit1_q && frow[3'd4 - x1_q];
    pix_d = lit ? CH_COLORS[24*ch1_q +: 24] : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      cnt_q        <= '0;
      sh_q         <= '0;
      bcd_q        <= '0;
      sat_q        <= 1'b0;
      pending_q    <= 1'b0;
      shadow_sat_q <= '0;
      active_sat_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        val_q[c] <= '0;
        for (int d = 0; d < DIGITS; d++) begin
          shadow_q[c][d] <= BLANK;
          active_q[c][d] <= BLANK;
        end
      end
      valid1_q <= 1'b0;
      hit1_q   <= 1'b0;
      ch1_q    <= '0;
      code1_q  <= BLANK;
      x1_q     <= '0;
      y1_q     <= '0;
      valid2_q <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      sat_q        <= sat_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      shadow_sat_q <= shadow_sat_d;
      active_sat_q <= active_sat_d;
      valid1_q     <= valid1_d;
      hit1_q       <= hit1_d;
      ch1_q        <= ch1_d;
      code1_q      <= code1_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      valid2_q     <= valid1_q;
      pix_q        <= pix_d;
    end
  end

  assign bus.values_ready = (state_q == S_IDLE);
  assign bus.pixel_data   = pix_q;
  assign bus.pixel_valid  = valid2_q;
  assign bus.overflow     = active_sat_q;
endmodule
